// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the transmitter and its matching receiver.
// Parity rule and default divider width live here so both sides agree.
package uart_pkg;

   localparam int UART_DATA_BITS        = 8;
   localparam int DEFAULT_DIVIDER_WIDTH = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   // Even: bit makes the total count of ones even; odd: makes it odd.
   function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data,
                                       input logic even);
      logic p;
      if (even) begin
         p = ^data;
      end else begin
         p = ~^data;
      end
      return p;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..divider-1 and flags the last clock of each bit.
// A divider of 0 behaves as 1; restart forces the count back to 0.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int DIVIDER_WIDTH = DEFAULT_DIVIDER_WIDTH
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic                     restart_i,
   input  logic [DIVIDER_WIDTH-1:0] divider_i,
   output logic                     tick_o
);

   logic [DIVIDER_WIDTH-1:0] count_q;
   logic [DIVIDER_WIDTH-1:0] count_d;
   logic [DIVIDER_WIDTH-1:0] last_s;

   always_comb begin
      if (divider_i == '0) begin
         last_s = '0;
      end else begin
         last_s = divider_i - DIVIDER_WIDTH'(1);
      end
      tick_o = (count_q == last_s);
      if (restart_i) begin
         count_d = '0;
      end else if (tick_o) begin
         count_d = '0;
      end else begin
         count_d = count_q + DIVIDER_WIDTH'(1);
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 / 8-parity-1 serial transmitter with a one-shot send handshake.
// A frame is accepted only when idle and send_i has been seen low since the last accept.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DIVIDER_WIDTH = DEFAULT_DIVIDER_WIDTH
) (
   input  logic                      clock_i,
   input  logic                      reset_i,
   input  logic                      send_i,
   input  logic [UART_DATA_BITS-1:0] data_i,
   input  logic                      parity_bit_i,
   input  logic                      parity_even_i,
   input  logic [DIVIDER_WIDTH-1:0]  clock_divider_i,
   output logic                      serial_o,
   output logic                      ready_o
);

   tx_state_e                 state_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic [2:0]                bit_idx_q;
   logic                      parity_en_q;
   logic                      parity_val_q;
   logic [DIVIDER_WIDTH-1:0]  divider_q;
   logic                      armed_q;
   logic                      serial_q;
   logic                      ready_q;
   logic                      accept_s;
   logic                      tick_s;

   assign accept_s = (state_q == IDLE) && armed_q && send_i;
   assign serial_o = serial_q;
   assign ready_o  = ready_q;

   uart_baud_tick #(
      .DIVIDER_WIDTH(DIVIDER_WIDTH)
   ) u_baud (
      .clock_i   (clock_i),
      .reset_i   (reset_i),
      .restart_i (accept_s),
      .divider_i (divider_q),
      .tick_o    (tick_s)
   );

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         bit_idx_q    <= 3'd0;
         parity_en_q  <= 1'b0;
         parity_val_q <= 1'b0;
         divider_q    <= DIVIDER_WIDTH'(1);
         armed_q      <= 1'b1;
         serial_q     <= 1'b1;
         ready_q      <= 1'b1;
      end else begin
         // Re-arm on any low sample; accept only happens with send_i high.
         if (!send_i) begin
            armed_q <= 1'b1;
         end else if (accept_s) begin
            armed_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               serial_q <= 1'b1;
               ready_q  <= 1'b1;
               if (accept_s) begin
                  shift_q      <= data_i;
                  parity_en_q  <= parity_bit_i;
                  parity_val_q <= parity_bit(data_i, parity_even_i);
                  divider_q    <= (clock_divider_i == '0) ? DIVIDER_WIDTH'(1) : clock_divider_i;
                  bit_idx_q    <= 3'd0;
                  state_q      <= START;
                  serial_q     <= 1'b0;
                  ready_q      <= 1'b0;
               end
            end
            START: begin
               if (tick_s) begin
                  state_q   <= DATA;
                  bit_idx_q <= 3'd0;
                  serial_q  <= shift_q[0];
               end
            end
            DATA: begin
               if (tick_s) begin
                  if (bit_idx_q == 3'd7) begin
                     if (parity_en_q) begin
                        state_q  <= PARITY;
                        serial_q <= parity_val_q;
                     end else begin
                        state_q  <= STOP;
                        serial_q <= 1'b1;
                     end
                  end else begin
                     shift_q   <= shift_q >> 1;
                     serial_q  <= shift_q[1];
                  end
                  bit_idx_q <= bit_idx_q + 3'd1;
               end
            end
            PARITY: begin
               if (tick_s) begin
                  state_q  <= STOP;
                  serial_q <= 1'b1;
               end
            end
            STOP: begin
               if (tick_s) begin
                  state_q  <= IDLE;
                  serial_q <= 1'b1;
                  ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q  <= IDLE;
               serial_q <= 1'b1;
               ready_q  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: every clock, serial_o and ready_o are compared
// against a reference that expands each accepted frame into a per-clock bit list.
module tb_uart_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        send;
   logic [7:0]  data;
   logic        pen;
   logic        peven;
   logic [15:0] div;
   logic        serial;
   logic        ready;

   int n_vec = 0;
   int n_err = 0;

   bit exp_ser  = 1'b1;
   bit exp_rdy  = 1'b1;
   bit m_armed  = 1'b1;
   bit line_q[$];

   always #5 clk = ~clk;

   uart_tx #(.DIVIDER_WIDTH(16)) dut (
      .clock_i         (clk),
      .reset_i         (rst),
      .send_i          (send),
      .data_i          (data),
      .parity_bit_i    (pen),
      .parity_even_i   (peven),
      .clock_divider_i (div),
      .serial_o        (serial),
      .ready_o         (ready)
   );

   task automatic chk(input string tag, input logic got, input logic exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // Line levels of one whole frame, each held for D clocks.
   task automatic push_frame(input logic [7:0] d, input logic p_en, input logic p_even,
                             input logic [15:0] dv);
      int  reps;
      int  ones;
      bit  bits[$];
      reps = (dv == 16'd0) ? 1 : int'(dv);
      ones = $countones(d);
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (p_en) bits.push_back(p_even ? bit'(ones % 2) : bit'(1 - (ones % 2)));
      bits.push_back(1'b1);
      foreach (bits[k]) for (int r = 0; r < reps; r++) line_q.push_back(bits[k]);
   endtask

   task automatic model_edge();
      bit accept;
      if (rst) begin
         line_q.delete();
         m_armed = 1'b1;
         exp_ser = 1'b1;
         exp_rdy = 1'b1;
      end else begin
         accept = exp_rdy && m_armed && send;
         if (!send) m_armed = 1'b1;
         if (accept) begin
            m_armed = 1'b0;
            push_frame(data, pen, peven, div);
         end
         if (line_q.size() > 0) begin
            exp_ser = line_q.pop_front();
            exp_rdy = 1'b0;
         end else begin
            exp_ser = 1'b1;
            exp_rdy = 1'b1;
         end
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk({tag, ".serial"}, serial, exp_ser);
      chk({tag, ".ready"},  ready,  exp_rdy);
   endtask

   task automatic run(input string tag, input int n, input bit scramble);
      for (int i = 0; i < n; i++) begin
         if (scramble) begin
            data  = 8'($urandom);
            pen   = 1'($urandom);
            peven = 1'($urandom);
            div   = 16'($urandom_range(0, 5));
         end
         step(tag);
      end
   endtask

   task automatic frame(input string tag, input logic [7:0] d, input logic p_en,
                        input logic p_even, input logic [15:0] dv, input int run_len);
      data  = d;
      pen   = p_en;
      peven = p_even;
      div   = dv;
      send  = 1'b1;
      step(tag);
      send  = 1'b0;
      run(tag, run_len, 1'b1);
   endtask

   initial begin
      rst = 1'b1; send = 1'b0; data = 8'h00; pen = 1'b0; peven = 1'b0; div = 16'd2;
      run("reset", 3, 1'b0);
      rst = 1'b0;
      run("idle", 3, 1'b0);

      frame("basic55", 8'h55, 1'b0, 1'b0, 16'd2, 22);
      frame("even55",  8'h55, 1'b1, 1'b1, 16'd2, 24);
      frame("even54",  8'h54, 1'b1, 1'b1, 16'd2, 24);
      frame("odd55",   8'h55, 1'b1, 1'b0, 16'd2, 24);

      // Held send_i gives one frame; a single low sample re-arms.
      data = 8'hAA; pen = 1'b0; peven = 1'b0; div = 16'd2; send = 1'b1;
      run("hold", 60, 1'b0);
      send = 1'b0;
      step("rearm");
      send = 1'b1;
      run("second", 25, 1'b0);
      send = 1'b0;
      run("second", 2, 1'b0);

      frame("div0", 8'hCC, 1'b0, 1'b0, 16'd0, 12);
      frame("div3", 8'h3C, 1'b1, 1'b0, 16'd3, 36);

      // Back-to-back: send held low except exactly at edges it is re-raised.
      data = 8'h0F; pen = 1'b0; div = 16'd1; send = 1'b1;
      step("b2b");
      send = 1'b0;
      run("b2b", 8, 1'b0);
      send = 1'b1;
      run("b2b", 14, 1'b0);
      send = 1'b0;

      // Reset during data bit 3 (D=2: start + bits 0..2 = 8 clocks).
      frame("midrst", 8'hF0, 1'b0, 1'b0, 16'd2, 8);
      rst = 1'b1;
      step("midrst");
      rst = 1'b0;
      run("postrst", 2, 1'b0);
      frame("postrst", 8'h96, 1'b1, 1'b1, 16'd2, 24);

      frame("div300", 8'hA5, 1'b1, 1'b0, 16'd300, 3305);

      for (int it = 0; it < 1500; it++) begin
         send  = ($urandom_range(0, 3) != 0);
         data  = 8'($urandom);
         pen   = 1'($urandom);
         peven = 1'($urandom);
         div   = 16'($urandom_range(0, 4));
         rst   = ($urandom_range(0, 199) == 0);
         step("rand");
      end
      rst = 1'b0; send = 1'b0;
      run("drain", 60, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8-bit asynchronous serial transmitter; the transmit-side counterpart of the team's UartRx block.
- Frame: start bit, 8 data bits LSB first, optional parity bit, one stop bit.
- Bit timing, parity options and the one-shot handshake style match the receiver, so the pair can be looped back for test.
- Sits between a host register interface and the TX pin.

Parameters:
- DIVIDER_WIDTH, 16, width of clock_divider_i and the internal baud counter

Ports:
- clock_i  in  1  system clock; all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- send_i  in  1  request to transmit data_i; one-shot, level must return low before another frame is accepted
- data_i  in  8  byte to transmit; sampled at accept
- parity_bit_i  in  1  1 = append parity bit; sampled at accept
- parity_even_i  in  1  1 = even parity, 0 = odd; sampled at accept
- clock_divider_i  in  DIVIDER_WIDTH  clocks per bit; sampled at accept; 0 treated as 1
- serial_o  out  1  TX line, idle high, registered
- ready_o  out  1  1 = idle and able to accept a frame, registered

Behaviour:
- Reset (reset_i high at a clock edge):
  - serial_o=1, ready_o=1, state IDLE, all counters 0, armed=1.
  - Reset mid-frame aborts the frame; serial_o is high after that edge.
- Armed flag:
  - Set on any edge where send_i is sampled low.
  - Cleared on accept.
- Accept: at an edge with state IDLE, armed=1 and send_i=1.
  - Latch data, parity config and divider D = max(clock_divider_i,1).
  - state -> START, serial_o -> 0, ready_o -> 0, baud counter -> 0.
- Holding send_i high after a frame sends nothing further. A new frame needs send_i low for at least one sampled edge, then high.
- Bit timing:
  - Each bit is driven on serial_o for exactly D clocks.
  - The baud counter counts 0..D-1; the edge at D-1 advances to the next bit and reloads 0.
- States and transitions:
  - IDLE: serial_o=1, ready_o=1.
  - START: drives 0; goes to DATA.
  - DATA: drives shift[0]; shift right each bit; the 3-bit index 0..7 wraps; after bit 7 goes to PARITY if parity is enabled, else STOP.
  - PARITY: drives ^data for even, ~^data for odd; goes to STOP.
  - STOP: drives 1; at the end of the stop bit goes to IDLE and ready_o -> 1.
- Frame length: D*10 clocks without parity, D*11 with parity. ready_o is low for exactly that many edges.
- Back-to-back frames:
  - Earliest next accept is the edge after ready_o returns high, so at least 1 idle clock (serial_o=1) separates frames.
  - send_i=1 at the edge where STOP ends is not accepted; it is accepted at the following edge if armed.
- Inputs are ignored while not IDLE; data_i and config may change freely mid-frame.
- Divider width: the counter compare is DIVIDER_WIDTH-bit unsigned; the maximum D of 65535 must work without overflow.

Decomposition:
- Package uart_pkg:
  - tx state enum (IDLE, START, DATA, PARITY, STOP)
  - UART_DATA_BITS=8
  - default DIVIDER_WIDTH
  - parity helper function (data, even) -> bit, also usable by the receiver
- One sub-module, uart_baud_tick:
  - inputs clock_i, reset_i, restart, divider
  - output tick on the last clock of each bit
  - reusable by the receiver

Test Plan:
- Basic frame: D=2, no parity, pulse send_i with 0x55 → serial_o is 0,1,0,1,0,1,0,1,0,1, each level 2 clocks; ready_o low for exactly 20 clocks, then high.
- Parity: D=2, 0x55 with even parity → parity bit 0; 0x54 with even parity → 1; 0x55 with odd parity → 1; ready_o low for 22 clocks.
- One-shot: hold send_i=1 for 60 clocks with 0xAA → exactly one frame; send_i low for 1 clock then high → second frame starts, with at least 1 idle-high clock between frames.
- Divider edge cases: D=0 with 0xCC → bits last 1 clock, 10-clock frame; D=3 → 30-clock frame; data_i changed mid-frame does not alter transmitted bits.
- Reset mid-frame: assert reset_i during data bit 3 → next edge serial_o=1, ready_o=1; then send_i high → new frame accepted normally.
- Loopback: connect to UartRx with the same divider and parity config; send 0x55, 0xAA, 0xCC with ack between → receiver data_o matches each byte and its ready_o rises once per frame.
